// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl
//   Single-level interrupt controller that sits beside a small CPU core.
//   Peripheral requests are latched into pending bits. At an instruction
//   boundary, with the global enable set, the lowest-index pending request is
//   taken: the return PC is saved, the enable is cleared, and a one-cycle
//   redirect pulse is raised. iret re-enables interrupts and ends the handler.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low reset
//   irq_src      peripheral requests, sampled every cycle
//   w_en/w_idx/w_data   register write strobe, index and data (w_intr)
//   r_idx/r_data        register read index and combinational data (r_intr)
//   instr_done   instruction-boundary pulse; next_pc is valid with it
//   next_pc      PC the CPU would execute next
//   iret         return-from-interrupt strobe
//   intr_take    one-cycle registered redirect pulse
//   intr_target  redirect address (intr_vec)
//   intr_en      global interrupt enable (idx1)
//   intr_epc     saved return PC (idx3)
//
// Register map
//   idx0 status : cause at [NUM_SRC+2:NUM_SRC] (bits 6:4 for 4 sources),
//                 pending at [NUM_SRC-1:0]; writes are W1C on pending
//   idx1 intr_en (bit 0)
//   idx2 intr_vec
//   idx3 intr_epc
//   others read 0, writes ignored
//
// State table
//   IDLE       | running normal code, may take an interrupt at instr_done
//   TAKE       | redirect cycle, intr_take is high
//   IN_HANDLER | executing the handler, waits for iret
// -----------------------------------------------------------------------------
module intr_ctrl #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               w_en,
  input  logic [3:0]         w_idx,
  input  logic [XLEN-1:0]    w_data,
  input  logic [3:0]         r_idx,
  output logic [XLEN-1:0]    r_data,
  input  logic               instr_done,
  input  logic [XLEN-1:0]    next_pc,
  input  logic               iret,
  output logic               intr_take,
  output logic [XLEN-1:0]    intr_target,
  output logic               intr_en,
  output logic [XLEN-1:0]    intr_epc
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    TAKE       = 2'd1,
    IN_HANDLER = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] pending, pending_nxt;
  logic [2:0]         cause, cause_nxt;
  logic               en_nxt;
  logic [XLEN-1:0]    intr_vec, vec_nxt;
  logic [XLEN-1:0]    epc_nxt;
  logic               take_nxt;

  logic               take_go;
  logic [2:0]         low_idx;
  logic [NUM_SRC-1:0] low_mask;
  logic [NUM_SRC-1:0] w1c_mask;

  // Lowest-index pending request; scanning downward lets index 0 win.
  always_comb begin
    low_idx  = 3'd0;
    low_mask = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) begin
        low_idx     = 3'(i);
        low_mask    = '0;
        low_mask[i] = 1'b1;
      end
    end
  end

  assign take_go  = (state == IDLE) && instr_done && intr_en && (|pending);
  assign w1c_mask = (w_en && (w_idx == 4'd0)) ? w_data[NUM_SRC-1:0] : '0;

  always_comb begin
    state_nxt   = state;
    en_nxt      = intr_en;
    vec_nxt     = intr_vec;
    epc_nxt     = intr_epc;
    cause_nxt   = cause;
    take_nxt    = 1'b0;
    // New requests are OR-ed in last so a coincident clear loses.
    pending_nxt = (pending & ~w1c_mask & ~(take_go ? low_mask : '0)) | irq_src;

    if (w_en && (w_idx == 4'd1)) en_nxt  = w_data[0];
    if (w_en && (w_idx == 4'd2)) vec_nxt = w_data;
    if (w_en && (w_idx == 4'd3)) epc_nxt = w_data;

    // iret re-enables from any state; it only changes state from IN_HANDLER.
    if (iret) en_nxt = 1'b1;

    case (state)
      IDLE: begin
        if (take_go) begin
          state_nxt = TAKE;
          en_nxt    = 1'b0;
          epc_nxt   = next_pc;
          cause_nxt = low_idx;
          take_nxt  = 1'b1;
        end
      end
      TAKE:       state_nxt = IN_HANDLER;
      IN_HANDLER: if (iret) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pending   <= '0;
      cause     <= 3'd0;
      intr_en   <= 1'b0;
      intr_vec  <= '0;
      intr_epc  <= '0;
      intr_take <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      cause     <= cause_nxt;
      intr_en   <= en_nxt;
      intr_vec  <= vec_nxt;
      intr_epc  <= epc_nxt;
      intr_take <= take_nxt;
    end
  end

  assign intr_target = intr_vec;

  // Reads always show the registered value, never same-cycle write data.
  always_comb begin
    r_data = '0;
    case (r_idx)
      4'd0: begin
        r_data[NUM_SRC-1:0]         = pending;
        r_data[NUM_SRC+2:NUM_SRC]   = cause;
      end
      4'd1:    r_data[0] = intr_en;
      4'd2:    r_data    = intr_vec;
      4'd3:    r_data    = intr_epc;
      default: r_data    = '0;
    endcase
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of interrupt registers and PC.
REQ-002 SHALL have parameter NUM_SRC, default 4, number of peripheral interrupt sources (1..8).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port irq_src  input  NUM_SRC  peripheral request pulses/levels, sampled each cycle.
REQ-006 SHALL have port w_en  input  1  CPU w_intr strobe.
REQ-007 SHALL have port w_idx  input  4  target register index (imm[3:0] of w_intr).
REQ-008 SHALL have port w_data  input  XLEN  value written (x[rs1]).
REQ-009 SHALL have port r_idx  input  4  read register index (imm[3:0] of r_intr).
REQ-010 SHALL have port r_data  output  XLEN  combinational read of selected register.
REQ-011 SHALL have port instr_done  input  1  CPU instruction-boundary pulse.
REQ-012 SHALL have port next_pc  input  XLEN  PC the CPU would execute next, valid with instr_done.
REQ-013 SHALL have port iret  input  1  CPU return-from-interrupt strobe.
REQ-014 SHALL have port intr_take  output  1  one-cycle registered pulse: CPU SHALL redirect to intr_target.
REQ-015 SHALL have port intr_target  output  XLEN  vector address, equals intr_vec.
REQ-016 SHALL have port intr_en  output  1  global enable (register index 1).
REQ-017 SHALL have port intr_epc  output  XLEN  saved return PC (register index 3).

Function
REQ-018 Register map SHALL be: idx0 status {cause[6:4], pending[NUM_SRC-1:0]}, idx1 intr_en (bit0), idx2 intr_vec, idx3 intr_epc; other indices read 0, writes ignored.
REQ-019 Writes SHALL take effect at the rising edge with w_en=1; idx1 stores w_data[0]; idx2/idx3 store full w_data.
REQ-020 Write to idx0 SHALL be write-1-to-clear on pending bits; cause field read-only.
REQ-021 pending[i] SHALL set at the edge after irq_src[i]=1 and stay set until cleared by take or W1C.
REQ-022 If set and clear of the same pending bit coincide, set SHALL win.
REQ-023 State machine SHALL have states IDLE, TAKE, IN_HANDLER.
REQ-024 IDLE->TAKE when instr_done=1 and registered intr_en=1 and any pending bit set.
REQ-025 On that edge: epc<=next_pc, intr_en<=0, cause<=lowest-index pending bit, that bit cleared, intr_take<=1.
REQ-026 TAKE->IN_HANDLER unconditionally next cycle; intr_take SHALL be high exactly one cycle.
REQ-027 IN_HANDLER->IDLE on iret=1; intr_en<=1 on the same edge; epc unchanged.
REQ-028 iret in IDLE or TAKE SHALL set intr_en<=1 and leave state unchanged.
REQ-029 Take decision SHALL use pre-edge intr_en; a simultaneous w_en to idx1 SHALL be overridden by the take's clear.
REQ-030 Simultaneous w_en to idx3 and take: take's epc capture SHALL win.
REQ-031 No nesting: no take while state != IDLE regardless of intr_en.
REQ-032 Lowest-index priority: irq_src[0] highest.
REQ-033 r_data SHALL reflect register contents before any same-cycle write (no write-through).

Reset
REQ-034 While reset=0: state=IDLE, pending=0, cause=0, intr_en=0, intr_vec=0, intr_epc=0, intr_take=0, asynchronously.
REQ-035 Reset mid-handler SHALL discard epc and pending; no intr_take after release until new request.
REQ-036 First edge after reset release SHALL behave as normal IDLE cycle.

Verification
REQ-037 w_en idx1 data 1, then idx2 data 7 -> intr_en=1, intr_vec=7, r_data(idx2)=7.
REQ-038 en=1, vec=0x40, irq_src=0b0110 pulse, instr_done with next_pc=0x1C -> intr_take 1 cycle, target 0x40, epc 0x1C, cause 1, pending 0b0100, intr_en 0.
REQ-039 In handler, irq_src[0] pulse then iret -> intr_en=1, next instr_done takes source 0, cause 0.
REQ-040 en=0, irq_src[3] pulse, instr_done -> no intr_take, pending bit3 set; W1C 0b1000 -> pending 0.
REQ-041 Take and w_en idx1 data 1 same edge -> intr_en=0, state IN_HANDLER.
REQ-042 reset=0 during IN_HANDLER with epc=0x1C -> all registers 0, state IDLE, no intr_take after release.
